// File: rtl/prac1_sweep_ctrl_pkg.sv
// Shared types and constants for the comparator-lab sweep controller:
// state encoding, vector width, default expected {F,G} table.
package prac1_sweep_ctrl_pkg;

  localparam int unsigned VEC_W = 4;

  // Default table encodes F = A>B, G = A==B for A={a1,a2}, B={b1,b2}.
  localparam logic [31:0] EXP_TABLE_DEFAULT = 32'h6A1A_0601;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [1:0] exp_fg(input logic [31:0] table_bits,
                                        input logic [VEC_W-1:0] vec);
    return table_bits[{vec, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/prac1_sweep_ctrl_if.sv
// Board/comparator-facing signal bundle of the sweep controller.
// master = controller side, slave = buttons/LEDs/comparator side.
interface prac1_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       f_in;
  logic       g_in;
  logic       a1;
  logic       a2;
  logic       b1;
  logic       b2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] fail_vec;

  modport master (
    input  start, abort, f_in, g_in,
    output a1, a2, b1, b2, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, abort, f_in, g_in,
    input  a1, a2, b1, b2, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/prac1_sweep_ctrl_hold_timer.sv
// Settle-window counter: counts 0..HOLD_CYCLES-1 while enabled, clears
// otherwise; tc flags the last cycle of the window.
module prac1_sweep_ctrl_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (en && !tc) cnt_d = cnt_q + HOLD_W'(1);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prac1_sweep_ctrl.sv
// Sweep sequencer for the 2-bit comparator lab: drives all 16 vectors,
// samples F/G after a settle window, tallies mismatches and the first failure.
module prac1_sweep_ctrl
  import prac1_sweep_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [31:0] EXP_TABLE   = EXP_TABLE_DEFAULT,
  parameter int unsigned HOLD_W      = 8
) (
  input logic                clk,
  input logic                rst_n,
  prac1_sweep_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [4:0]       err_q, err_d;
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;
  logic             hold_tc;
  logic             mismatch;

  prac1_sweep_ctrl_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_DRIVE),
    .tc    (hold_tc)
  );

  assign mismatch = ({bus.f_in, bus.g_in} != exp_fg(EXP_TABLE, vec_q));

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        vec_d = '0;
        // abort in the same cycle suppresses a start
        if (bus.start && !bus.abort) begin
          state_d = ST_DRIVE;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      ST_DRIVE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
        end else if (hold_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
        end else begin
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == '1) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            state_d = ST_DRIVE;
            vec_d   = vec_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign {bus.a1, bus.a2, bus.b1, bus.b2} = vec_q;
  assign bus.busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;

endmodule
